// File: rtl/cpu_sequencer_pkg.sv
// lib_cpu: shared opcodes, sequencer states and widths for the 4-bit CPU core
package lib_cpu;
    localparam int INSTR_W = 8;
    localparam int DATA_W  = 4;

    typedef enum logic [3:0] {
        ADD_A_IMM = 4'h0,
        MOV_A_B   = 4'h1,
        IN_A      = 4'h2,
        MOV_A_IMM = 4'h3,
        MOV_B_A   = 4'h4,
        ADD_B_IMM = 4'h5,
        IN_B      = 4'h6,
        MOV_B_IMM = 4'h7,
        INVALID   = 4'h8,
        OUT_B     = 4'h9,
        OUT_IMM   = 4'hB,
        JNC_IMM   = 4'hE,
        JMP_IMM   = 4'hF
    } opecode_t;

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, FAULT, STEP_WAIT} seq_state_t;
endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: ROM fetch handshake plus instruction/decode exchange with the external decoder
interface cpu_sequencer_if
    import lib_cpu::*;
#(
    parameter int ADDR_W = 4
);
    logic               rom_req;
    logic [ADDR_W-1:0]  rom_addr;
    logic               rom_ack;
    logic [INSTR_W-1:0] rom_data;
    logic [INSTR_W-1:0] ir;
    opecode_t           opecode;
    logic [DATA_W-1:0]  imm;

    modport master (output rom_req, rom_addr, ir, input rom_ack, rom_data, opecode, imm);
    modport slave  (input rom_req, rom_addr, ir, output rom_ack, rom_data, opecode, imm);
endinterface

// File: rtl/cpu_sequencer_alu.sv
// cpu_alu: 4-bit adder returning {carry,sum}, or passes y straight through for moves and inputs
module cpu_alu
    import lib_cpu::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic              add,
    output logic [DATA_W:0]   res
);
    assign res = add ? {1'b0, x} + {1'b0, y} : {1'b0, y};
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/execute control for the 4-bit CPU; defining CPU_SINGLE_STEP_EN adds a step input
module cpu_sequencer
    import lib_cpu::*;
#(
    parameter int              ADDR_W          = 4,
    parameter logic [ADDR_W-1:0] RESET_PC      = '0,
    parameter bit              HALT_ON_INVALID = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
`ifdef CPU_SINGLE_STEP_EN
    input  logic              step,
`endif
    cpu_sequencer_if.master   bus,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port,
    output logic              out_we,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic              carry,
    output logic              busy,
    output logic              fault
);
    seq_state_t         state, state_nx;
    logic [ADDR_W-1:0]  pc, pc_nx;
    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  a_nx, b_nx, out_nx, x, y;
    logic [DATA_W:0]    res;
    logic               carry_nx, we_nx, add, wr_a, wr_b, halt;
    opecode_t           op;

`ifdef CPU_SINGLE_STEP_EN
    localparam seq_state_t AFTER_EXEC = STEP_WAIT;
    logic step_q, step_edge;
    assign step_edge = step && !step_q;
`else
    localparam seq_state_t AFTER_EXEC = FETCH;
`endif

    assign op   = bus.opecode;
    assign add  = op inside {ADD_A_IMM, ADD_B_IMM};
    assign wr_a = op inside {ADD_A_IMM, MOV_A_B, IN_A, MOV_A_IMM};
    assign wr_b = op inside {ADD_B_IMM, MOV_B_A, IN_B, MOV_B_IMM};
    assign x    = wr_b ? reg_b : reg_a;
    assign y    = op == MOV_A_B ? reg_b : op == MOV_B_A ? reg_a : op inside {IN_A, IN_B} ? in_port : bus.imm;
    assign halt = HALT_ON_INVALID && op == INVALID;

    assign bus.rom_req  = state == FETCH;
    assign bus.rom_addr = pc;
    assign bus.ir       = ir;
    assign busy         = state inside {FETCH, EXEC};
    assign fault        = state == FAULT;

    cpu_alu alu (.x(x), .y(y), .add(add), .res(res));

    // next state and the architectural updates committed at the end of EXEC
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        a_nx     = reg_a;
        b_nx     = reg_b;
        carry_nx = carry;
        out_nx   = out_port;
        we_nx    = 1'b0;
        case (state)
            IDLE:  state_nx = run ? FETCH : IDLE;
            FETCH: state_nx = bus.rom_ack ? EXEC : FETCH;
            EXEC: begin
                state_nx = halt ? FAULT : run ? AFTER_EXEC : IDLE;
                if (!halt) begin
                    pc_nx    = (op == JMP_IMM || (op == JNC_IMM && !carry)) ? ADDR_W'(bus.imm) : pc + 1'b1;
                    a_nx     = wr_a ? res[DATA_W-1:0] : reg_a;
                    b_nx     = wr_b ? res[DATA_W-1:0] : reg_b;
                    carry_nx = add && res[DATA_W];
                    we_nx    = op inside {OUT_B, OUT_IMM};
                    out_nx   = op == OUT_B ? reg_b : op == OUT_IMM ? bus.imm : out_port;
                end
            end
`ifdef CPU_SINGLE_STEP_EN
            STEP_WAIT: state_nx = !run ? IDLE : step_edge ? FETCH : STEP_WAIT;
`endif
            default: state_nx = state;
        endcase
    end

    // state and architectural registers; ir captures the byte on the accepted fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            ir       <= '0;
            reg_a    <= '0;
            reg_b    <= '0;
            carry    <= 1'b0;
            out_port <= '0;
            out_we   <= 1'b0;
`ifdef CPU_SINGLE_STEP_EN
            step_q   <= 1'b0;
`endif
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            ir       <= (state == FETCH && bus.rom_ack) ? bus.rom_data : ir;
            reg_a    <= a_nx;
            reg_b    <= b_nx;
            carry    <= carry_nx;
            out_port <= out_nx;
            out_we   <= we_nx;
`ifdef CPU_SINGLE_STEP_EN
            step_q   <= step;
`endif
        end
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed programs with a retire scoreboard and queued point checks
module tb_cpu_sequencer;
    import lib_cpu::*;

    typedef struct packed {
        logic [3:0] pc, a, b;
        logic       c;
        logic [3:0] o;
        logic       we, f;
    } snap_t;

    typedef enum int {
        S_PC, S_A, S_B, S_C, S_OUT, S_WE, S_REQ, S_BUSY, S_FAULT, S_IR,
        S2_PC, S2_A, S2_B, S2_C, S2_OUT, S2_WE, S2_BUSY, S2_FAULT, S_RQ
    } sel_t;

    typedef struct {
        string name;
        sel_t  sel;
        int    exp;
    } chk_t;

    logic       clk = 1'b0;
    logic       rst_n, run, run2, step, force_ack;
    logic [3:0] in_port = 4'h9;
    logic [3:0] out_port, reg_a, reg_b, out_port2, reg_a2, reg_b2;
    logic       out_we, carry, busy, fault, out_we2, carry2, busy2, fault2;
    logic [7:0] rom [16];
    int         wait_n = 0, wcnt = 0, n_run = 0, n_fail = 0;
    bit         was_exec = 1'b0;
    snap_t      rq[$];
    chk_t       dq[$];
    snap_t      se, sa;
    chk_t       cc;

    cpu_sequencer_if #(.ADDR_W(4)) bus ();
    cpu_sequencer_if #(.ADDR_W(4)) bus2 ();

    function automatic opecode_t dec(input logic [3:0] h);
        return h inside {4'h8, 4'hA, 4'hC, 4'hD} ? INVALID : opecode_t'(h);
    endfunction

    assign bus.rom_ack   = (bus.rom_req && wcnt == wait_n) || force_ack;
    assign bus.rom_data  = rom[bus.rom_addr];
    assign bus.opecode   = dec(bus.ir[7:4]);
    assign bus.imm       = bus.ir[3:0];
    assign bus2.rom_ack  = bus2.rom_req;
    assign bus2.rom_data = rom[bus2.rom_addr];
    assign bus2.opecode  = dec(bus2.ir[7:4]);
    assign bus2.imm      = bus2.ir[3:0];

    always #5 clk = ~clk;

    always @(posedge clk) wcnt <= (bus.rom_req && !bus.rom_ack) ? wcnt + 1 : 0;

    cpu_sequencer #(.ADDR_W(4), .RESET_PC(4'd0), .HALT_ON_INVALID(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
`ifdef CPU_SINGLE_STEP_EN
        .step(step),
`endif
        .bus(bus), .in_port(in_port), .out_port(out_port), .out_we(out_we),
        .reg_a(reg_a), .reg_b(reg_b), .carry(carry), .busy(busy), .fault(fault)
    );

    cpu_sequencer #(.ADDR_W(4), .RESET_PC(4'd0), .HALT_ON_INVALID(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .run(run2),
`ifdef CPU_SINGLE_STEP_EN
        .step(step),
`endif
        .bus(bus2), .in_port(in_port), .out_port(out_port2), .out_we(out_we2),
        .reg_a(reg_a2), .reg_b(reg_b2), .carry(carry2), .busy(busy2), .fault(fault2)
    );

    function automatic int obs(input sel_t s);
        case (s)
            S_PC:     return int'(bus.rom_addr);
            S_A:      return int'(reg_a);
            S_B:      return int'(reg_b);
            S_C:      return int'(carry);
            S_OUT:    return int'(out_port);
            S_WE:     return int'(out_we);
            S_REQ:    return int'(bus.rom_req);
            S_BUSY:   return int'(busy);
            S_FAULT:  return int'(fault);
            S_IR:     return int'(bus.ir);
            S2_PC:    return int'(bus2.rom_addr);
            S2_A:     return int'(reg_a2);
            S2_B:     return int'(reg_b2);
            S2_C:     return int'(carry2);
            S2_OUT:   return int'(out_port2);
            S2_WE:    return int'(out_we2);
            S2_BUSY:  return int'(busy2);
            S2_FAULT: return int'(fault2);
            S_RQ:     return rq.size();
            default:  return -1;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input sel_t sel, input int exp);
        dq.push_back('{name, sel, exp});
    endtask

    task automatic ret(input logic [3:0] pc, a, b, input logic c, input logic [3:0] o, input logic we, f);
        rq.push_back({pc, a, b, c, o, we, f});
    endtask

    task automatic rst_pulse();
        tick(1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 16; i++) rom[i] = v;
    endtask

    // monitor: point checks queued at a falling edge, and one snapshot compare per retired instruction
    initial begin
        forever begin
            @(negedge clk);
            #1;
            while (dq.size() > 0) begin
                cc = dq.pop_front();
                n_run++;
                if (obs(cc.sel) != cc.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %0d, expected %0d", cc.name, obs(cc.sel), cc.exp);
                end
            end
            if (was_exec) begin
                n_run++;
                sa = {bus.rom_addr, reg_a, reg_b, carry, out_port, out_we, fault};
                if (rq.size() == 0) begin
                    n_fail++;
                    $display("FAIL retire: unexpected instruction retired, pc=%h", sa.pc);
                end else begin
                    se = rq.pop_front();
                    if (sa !== se) begin
                        n_fail++;
                        $display("FAIL retire: got pc=%h a=%h b=%h c=%b out=%h we=%b fault=%b, expected pc=%h a=%h b=%h c=%b out=%h we=%b fault=%b",
                                 sa.pc, sa.a, sa.b, sa.c, sa.o, sa.we, sa.f, se.pc, se.a, se.b, se.c, se.o, se.we, se.f);
                    end
                end
            end
            was_exec = rst_n && busy && !bus.rom_req;
        end
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; run2 = 1'b0; step = 1'b0; force_ack = 1'b0;
        fill(8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("rst_pc", S_PC, 0); chk("rst_a", S_A, 0); chk("rst_b", S_B, 0); chk("rst_c", S_C, 0);
        chk("rst_out", S_OUT, 0); chk("rst_we", S_WE, 0); chk("rst_req", S_REQ, 0);
        chk("rst_fault", S_FAULT, 0); chk("rst_busy", S_BUSY, 0); chk("rst_ir", S_IR, 0);
        tick(3);
        chk("idle_req", S_REQ, 0);
        // program 1, zero-wait ROM
        rom[0] = 8'h33; rom[1] = 8'h0E; rom[2] = 8'hE5; rom[3] = 8'hB7;
        ret(1, 3, 0, 0, 0, 0, 0);
        ret(2, 1, 0, 1, 0, 0, 0);
        ret(3, 1, 0, 0, 0, 0, 0);
        ret(4, 1, 0, 0, 7, 1, 0);
        run = 1'b1;
        tick(1);
        chk("fetch_req", S_REQ, 1); chk("fetch_addr", S_PC, 0);
        tick(7);
        chk("busy_in_exec3", S_BUSY, 1);
        run = 1'b0;
        tick(1);
        chk("done_after_8", S_BUSY, 0);
        tick(1);
        chk("we_single_pulse", S_WE, 0); chk("out_hold", S_OUT, 7);
        // program 1 again with three ROM wait cycles
        rst_pulse();
        wait_n = 3;
        ret(1, 3, 0, 0, 0, 0, 0);
        ret(2, 1, 0, 1, 0, 0, 0);
        ret(3, 1, 0, 0, 0, 0, 0);
        ret(4, 1, 0, 0, 7, 1, 0);
        run = 1'b1;
        tick(2);
        chk("wait_addr1", S_PC, 0); chk("wait_req1", S_REQ, 1);
        tick(2);
        chk("wait_addr2", S_PC, 0); chk("wait_req2", S_REQ, 1);
        tick(1);
        chk("wait_exec_busy", S_BUSY, 1); chk("wait_exec_req", S_REQ, 0);
        tick(15);
        run = 1'b0;
        tick(2);
        chk("wait_idle", S_BUSY, 0);
        // program 2: ADD overflow and JMP loop
        rst_pulse();
        wait_n = 0;
        fill(8'h00);
        rom[0] = 8'h7F; rom[1] = 8'h51; rom[2] = 8'hF0;
        for (int k = 0; k < 2; k++) begin
            ret(1, 0, 4'hF, 0, 0, 0, 0);
            ret(2, 0, 0, 1, 0, 0, 0);
            ret(0, 0, 0, 0, 0, 0, 0);
        end
        run = 1'b1;
        tick(12);
        run = 1'b0;
        tick(2);
        chk("loop_pc", S_PC, 0);
        // PC wrap through 15 -> 0
        rst_pulse();
        fill(8'h30);
        for (int k = 0; k < 17; k++) ret(4'((k + 1) % 16), 0, 0, 0, 0, 0, 0);
        run = 1'b1;
        tick(34);
        run = 1'b0;
        tick(2);
        chk("wrap_pc", S_PC, 1);
        // INVALID opcode: halting instance and NOP instance side by side
        rst_pulse();
        fill(8'h00);
        rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'h85;
        ret(1, 4'hF, 0, 0, 0, 0, 0);
        ret(2, 0, 0, 1, 0, 0, 0);
        ret(2, 0, 0, 1, 0, 0, 1);
        run = 1'b1; run2 = 1'b1;
        tick(6);
        run2 = 1'b0;
        tick(1);
        chk("nohalt_pc", S2_PC, 3); chk("nohalt_c", S2_C, 0); chk("nohalt_a", S2_A, 0);
        chk("nohalt_b", S2_B, 0); chk("nohalt_out", S2_OUT, 0); chk("nohalt_we", S2_WE, 0);
        chk("nohalt_fault", S2_FAULT, 0); chk("nohalt_busy", S2_BUSY, 0);
        tick(4);
        chk("halt_req", S_REQ, 0); chk("halt_fault", S_FAULT, 1); chk("halt_pc", S_PC, 2);
        chk("halt_busy", S_BUSY, 0); chk("halt_c", S_C, 1); chk("halt_a", S_A, 0);
        run = 1'b0;
        rst_pulse();
        chk("fault_cleared", S_FAULT, 0); chk("fault_rst_pc", S_PC, 0);
        // reset during FETCH with an ack pending before and after release
        wait_n = 100;
        run = 1'b1;
        tick(2);
        chk("midfetch_req_before", S_REQ, 1);
        tick(1);
        rst_n = 1'b0; run = 1'b0; force_ack = 1'b1;
        chk("async_req_drop", S_REQ, 0); chk("async_busy", S_BUSY, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        chk("late_ack_req", S_REQ, 0); chk("late_ack_busy", S_BUSY, 0);
        chk("late_ack_ir", S_IR, 0); chk("late_ack_pc", S_PC, 0);
        force_ack = 1'b0;
        tick(1);
        chk("sb_empty", S_RQ, 0);
        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control unit for the 4-bit CPU core.
- Fetches instruction bytes from program ROM over a req/ack handshake and presents the instruction register to the external decoder.
- Takes back the decoded OPECODE and imm, and executes: updates A, B, carry, PC and the output port.
- Sits between the ROM interface, the decoder and board I/O inside the CPU top level.

Parameters:
ADDR_W, 4, PC and ROM address width; PC wraps modulo 2**ADDR_W.
RESET_PC, 0, PC value loaded on reset.
HALT_ON_INVALID, 1, 1: an INVALID opecode enters FAULT; 0: INVALID executes as NOP (PC+1, carry cleared).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
run  in  1  level; 1 allows instruction fetch.
rom_req  out  1  fetch request; held until rom_ack.
rom_addr  out  ADDR_W  fetch address, equal to PC; stable while rom_req=1.
rom_ack  in  1  ROM data valid this cycle; may assert in the same cycle as rom_req.
rom_data  in  8  instruction byte, sampled when rom_req&&rom_ack.
ir  out  8  instruction register, drives decoder input.
opecode  in  OPECODE  decoded operation, combinational from ir.
imm  in  4  immediate, combinational from ir.
in_port  in  4  input switches, sampled in EXEC.
out_port  out  4  registered output port.
out_we  out  1  one-cycle pulse when out_port is written.
reg_a, reg_b  out  4 each  architectural registers (debug/verification).
carry  out  1  carry flag.
busy  out  1  1 in FETCH or EXEC.
fault  out  1  1 in FAULT.

Behaviour:
- Reset (async assert, sync release): state=IDLE, PC=RESET_PC, A=B=0, carry=0, ir=0, out_port=0, out_we=0, rom_req=0, fault=0.
- States:
  - IDLE: rom_req=0. If run=1, go to FETCH next cycle.
  - FETCH: rom_req=1, rom_addr=PC. On rom_ack: ir<=rom_data, go to EXEC. Otherwise stay. run is ignored once FETCH is entered; the fetch always completes.
  - EXEC: one cycle using opecode/imm decoded from ir. Next state is FETCH if run=1, else IDLE. If INVALID and HALT_ON_INVALID=1, next state is FAULT and no register, PC or port update occurs.
  - FAULT: terminal. fault=1, rom_req=0. Exit only by reset.
- EXEC semantics (PC<=PC+1 unless noted; carry<=0 on every instruction except ADD):
  - MOV_A_B: A<=B. MOV_B_A: B<=A.
  - MOV_A_IMM: A<=imm. MOV_B_IMM: B<=imm.
  - IN_A: A<=in_port. IN_B: B<=in_port.
  - OUT_B: out_port<=B, out_we=1. OUT_IMM: out_port<=imm, out_we=1.
  - ADD_A_IMM: {carry,A}<=A+imm, 5-bit sum. ADD_B_IMM: {carry,B}<=B+imm.
  - JMP_IMM: PC<=imm, zero-extended to ADDR_W.
  - JNC_IMM: PC<=imm if carry==0, else PC+1. carry<=0 afterwards.
- Throughput: 2 cycles per instruction with a zero-wait ROM (rom_ack in the same cycle as the request). Each ROM wait cycle adds one cycle.
- PC increment wraps from 2**ADDR_W-1 to 0.
- out_we is high only in the cycle after EXEC of an OUT; out_port holds its value otherwise.
- Asynchronous reset mid-FETCH drops rom_req immediately; a late rom_ack is ignored.

Optional Feature:
CPU_SINGLE_STEP_EN
- With the macro: adds input step (1 bit, rising-edge detected internally) and a STEP_WAIT state.
  - After EXEC, the FSM enters STEP_WAIT instead of FETCH.
  - It leaves STEP_WAIT for FETCH on a detected step edge while run=1, or for IDLE if run=0.
  - Result: one instruction per step edge.
- Without the macro: no step port, no STEP_WAIT state; execution is free-running as described above.

Decomposition:
- lib_cpu package: OPECODE enum (existing); SEQ_STATE enum {IDLE, FETCH, EXEC, FAULT, STEP_WAIT}; localparam INSTR_W=8; localparam DATA_W=4.
- One sub-module, cpu_alu: combinational 4-bit adder producing {carry,sum} from operand and imm, with a pass-through select for MOV/IN. The sequencer owns all state; the decoder stays outside.

Test Plan:
- Reset with run=0: all outputs at reset values, rom_req=0 indefinitely. Raise run: rom_req=1, rom_addr=0 on the next cycle.
- ROM {0x33,0x0E,0xE5,0xB7}, zero-wait:
  - after instr 2: A=1, carry=1.
  - JNC not taken: PC=3.
  - OUT 7: out_port=7, one out_we pulse, carry=0.
  - 8 cycles in total.
- ROM {0x7F,0x51,0xF0}: B=0 with carry=1 after ADD; JMP returns PC to 0; pattern repeats. Also check PC wrap 15->0 with a ROM filled with 0x30.
- ROM ack delayed by 3 cycles: rom_addr stays stable, instruction latency is 5 cycles, and results match the zero-wait run.
- Byte 0x8x (INVALID) with HALT_ON_INVALID=1: fault=1, A/B/PC frozen, rom_req=0 until rst_n pulse. With HALT_ON_INVALID=0: PC+1, carry=0.
- rst_n asserted mid-FETCH with a pending ack: immediate reset values; an ack arriving after release is ignored. With CPU_SINGLE_STEP_EN: exactly one instruction per step edge.
